crc_16_frame_tx: RTL and testbench
==================================

// Module: crc_16_frame_tx
// PURPOSE
//  Upstream feeder for the CRC-16-ANSI serial checker/generator. Accepts one parallel word per
//  frame over a valid/ready handshake and shifts its valid bits out LSB-first, one per clock.
//  Computes CRC-16-ANSI on the fly and appends the 16-bit CRC, MSB-first.
//  A CRC-16-ANSI receiver fed the whole frame (data + CRC) ends with residue 16'h0000.
// PARAMETERS
//  DATA_W   16                 parallel word width; power of 2, >= 2
//  MOD_W    $clog2(DATA_W)     width of data_mod_i
// PORTS
//  clk_i           in   1        single clock; all logic on posedge
//  rst_i           in   1        asynchronous reset, active-high
//  data_i          in   DATA_W   parallel payload; bit 0 transmitted first
//  data_mod_i      in   MOD_W    number of valid payload bits, data_i[0 +: n]; 0 means DATA_W
//  data_val_i      in   1        payload valid
//  ready_o         out  1        block can accept a word this cycle
//  ser_data_o      out  1        serial bit (payload, then CRC)
//  ser_data_val_o  out  1        ser_data_o is valid
//  ser_crc_o       out  1        current serial bit is a CRC bit
//  ser_last_o      out  1        current bit is the final CRC bit (crc[0])
//  busy_o          out  1        frame in progress (DATA or CRC state)
// BEHAVIOUR
//  - CRC: poly 0x8005, init 16'h0000, no reflection, no final XOR.
//    Per payload bit b: fb = crc[15]^b; crc = {crc[14:0],fb} ^ (fb ? 16'h8004 : 0). Net taps: bits 0, 2, 15.
//  - FSM IDLE -> DATA -> CRC -> IDLE. All outputs registered.
//  - Reset (async, any state): FSM=IDLE, CRC reg=0, bit counter=0, every output=0 including ready_o.
//    ready_o rises on the first clock edge after rst_i deasserts.
//  - IDLE: ready_o=1. On a posedge with data_val_i&&ready_o, the block:
//    latches data_i; sets n = (data_mod_i==0) ? DATA_W : data_mod_i; clears CRC; enters DATA; ready_o->0.
//  - DATA: the first payload bit appears on ser_data_o one cycle after the accept edge.
//    Bits go out data[0]..data[n-1], one per cycle, with ser_data_val_o=1 and ser_crc_o=0.
//    The CRC updates with each bit as it is emitted.
//  - CRC: the 16 cycles immediately after the last payload bit (no gap).
//    Bits crc[15]..crc[0] of the final CRC are emitted with ser_data_val_o=1 and ser_crc_o=1.
//    ser_last_o=1 only on the crc[0] cycle.
//  - After the last CRC bit: FSM=IDLE; ser_*_o=0; ready_o=1 in the next cycle.
//    There is exactly one idle cycle between frames.
//  - Frame length on the serial side is n+16 cycles; busy_o is high for exactly those cycles.
//  - data_val_i while ready_o=0 is ignored; no buffering.
//  - data_i and data_mod_i are sampled only at the accept edge; later changes do not affect the frame.
//  - rst_i mid-frame aborts immediately: outputs drop to 0 asynchronously and no partial CRC is emitted.
//  - data_mod_i values 1..DATA_W-1 are legal; n=1 is a valid 17-bit frame.
// STRUCTURE
//  - Shared package crc_pkg:
//    CRC16_ANSI_POLY = 16'h8005, CRC16_INIT = 16'h0000, CRC_W = 16;
//    function crc16_ansi_next(crc, bit) implementing the one-bit update;
//    typedef enum {IDLE, DATA, CRC} tx_state_t.
//  - One sub-module: crc_16_ansi_lfsr (clk_i, rst_i, clr_i, en_i, bit_i, crc_o), a one-bit-per-cycle CRC register.
//  - The top holds the FSM, payload shift register, and down-counter (width $clog2(DATA_W)+1, reused for the 16 CRC bits).
// TESTING
//  1. Reset: hold rst_i=1 3 cycles -> all outputs 0. Release -> ready_o=1 after 1 edge.
//  2. data_i=16'h0001, mod=1 -> serial 1, then CRC 16'h8005 MSB-first.
//     ser_last_o on cycle 17; busy_o high 17 cycles.
//  3. data_i=16'h0003, mod=2 -> bits 1,1, then CRC 16'h000A (0000_0000_0000_1010).
//     ser_crc_o high on cycles 3..18.
//  4. data_i=16'h0000, mod=0 -> 16 zero bits + CRC 16'h0000. 32 valid cycles; ready_o=1 one cycle later.
//  5. data_val_i held high with random data and mod for 10 frames.
//     -> one idle cycle between frames; each CRC equals the bench model.
//     Data+CRC through the model gives residue 0.
//  6. Assert rst_i on payload bit 5 of a mod=0 frame -> outputs 0 same cycle; no CRC bits.
//     The next frame, 16'hFFFF mod=0, is correct against the model.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-16-ANSI definitions: polynomial, init value, one-bit update and TX states.
package crc_pkg;

    localparam int              CRC_W           = 16;
    localparam logic [CRC_W-1:0] CRC16_ANSI_POLY = 16'h8005;
    localparam logic [CRC_W-1:0] CRC16_INIT      = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CRC
    } tx_state_t;

    // One serial bit into a non-reflected CRC-16-ANSI register.
    // Poly bit 0 is supplied by the feedback bit shifted in at the bottom.
    function automatic logic [CRC_W-1:0] crc16_ansi_next(input logic [CRC_W-1:0] crc,
                                                         input logic             din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], fb} ^ (fb ? {CRC16_ANSI_POLY[CRC_W-1:1], 1'b0} : '0);
    endfunction

endpackage

// File: rtl/crc_16_ansi_lfsr.sv
// One-bit-per-cycle CRC-16-ANSI register with synchronous clear.
import crc_pkg::*;

module crc_16_ansi_lfsr (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q;

    // Clear restarts from the init value; a bit presented with clear is folded in at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC16_INIT;
        end else if (en_i) begin
            crc_q <= crc16_ansi_next(clr_i ? CRC16_INIT : crc_q, bit_i);
        end else if (clr_i) begin
            crc_q <= CRC16_INIT;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc_16_frame_tx.sv
// Serialises one parallel word per frame LSB-first, then appends its CRC-16-ANSI MSB-first.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready_o high, waiting for data_val_i; serial outputs low
//   DATA  | shifting payload bits out, CRC absorbing each emitted bit
//   CRC   | shifting the frozen CRC out, crc[15] first, crc[0] last
import crc_pkg::*;

module crc_16_frame_tx #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_crc_o,
    output logic              ser_last_o,
    output logic              busy_o
);

    // Counter spans both the payload and the 16 CRC bits; equals $clog2(DATA_W)+1 for DATA_W >= 16.
    localparam int CNT_W = ($clog2(DATA_W) > $clog2(CRC_W)) ? $clog2(DATA_W) + 1 : $clog2(CRC_W) + 1;
    localparam int IDX_W = $clog2(CRC_W);

    tx_state_t        state;
    logic [DATA_W-1:0] sh;
    logic [CNT_W-1:0]  cnt;
    logic [CRC_W-1:0]  crc;
    logic [IDX_W-1:0]  crc_idx;
    logic              accept;
    logic              lfsr_en;
    logic              lfsr_bit;

    assign accept   = (state == IDLE) && ready_o && data_val_i;
    // The CRC absorbs each payload bit on the same edge that puts it on ser_data_o,
    // so the final CRC is already settled when the CRC phase starts.
    assign lfsr_en  = accept || ((state == DATA) && (cnt != '0));
    assign lfsr_bit = accept ? data_i[0] : sh[0];
    assign crc_idx  = IDX_W'(cnt - CNT_W'(1));

    crc_16_ansi_lfsr u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (accept),
        .en_i  (lfsr_en),
        .bit_i (lfsr_bit),
        .crc_o (crc)
    );

    // Frame sequencer: payload shift register, shared down-counter and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            sh             <= '0;
            cnt            <= '0;
            ready_o        <= 1'b0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            ser_crc_o      <= 1'b0;
            ser_last_o     <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state          <= DATA;
                        sh             <= data_i >> 1;
                        cnt            <= (data_mod_i == '0) ? CNT_W'(DATA_W - 1)
                                                             : CNT_W'(data_mod_i) - CNT_W'(1);
                        ready_o        <= 1'b0;
                        ser_data_o     <= data_i[0];
                        ser_data_val_o <= 1'b1;
                        busy_o         <= 1'b1;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        state      <= CRC;
                        cnt        <= CNT_W'(CRC_W - 1);
                        ser_data_o <= crc[CRC_W-1];
                        ser_crc_o  <= 1'b1;
                    end else begin
                        sh         <= sh >> 1;
                        cnt        <= cnt - CNT_W'(1);
                        ser_data_o <= sh[0];
                    end
                end
                CRC: begin
                    if (cnt == '0) begin
                        state          <= IDLE;
                        ready_o        <= 1'b1;
                        ser_data_o     <= 1'b0;
                        ser_data_val_o <= 1'b0;
                        ser_crc_o      <= 1'b0;
                        ser_last_o     <= 1'b0;
                        busy_o         <= 1'b0;
                    end else begin
                        cnt        <= cnt - CNT_W'(1);
                        ser_data_o <= crc[crc_idx];
                        ser_last_o <= (cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_16_frame_tx.sv
// Scoreboard bench for crc_16_frame_tx: stimulus pushes expected serial bits, a monitor pops and checks.
module tb_crc_16_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_i = '0;
    logic [3:0]  data_mod_i = '0;
    logic        data_val_i = 1'b0;
    logic        ready_o, ser_data_o, ser_data_val_o, ser_crc_o, ser_last_o, busy_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic d;
        logic c;
        logic l;
    } exp_t;

    exp_t exp_q[$];
    int   gap_q[$];
    int   len_q[$];

    always #5 clk = ~clk;

    crc_16_frame_tx #(.DATA_W(16), .MOD_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ready_o        (ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .ser_crc_o      (ser_crc_o),
        .ser_last_o     (ser_last_o),
        .busy_o         (busy_o)
    );

    function automatic logic [15:0] m_next(input logic [15:0] crc, input logic b);
        logic [15:0] r;
        r = crc << 1;
        if (crc[15] ^ b) r = r ^ 16'h8005;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the expected frame, offer it, and return 1 time unit after the accept edge.
    task automatic send(input logic [15:0] d, input logic [3:0] m, input int gap,
                        input bit hand, input logic [15:0] hcrc, input bit keep);
        int n;
        int t;
        logic [15:0] c;
        exp_t e;
        n = (m == 0) ? 16 : int'(m);
        c = 16'h0000;
        for (int i = 0; i < n; i++) begin
            e = '{d: d[i], c: 1'b0, l: 1'b0};
            exp_q.push_back(e);
            c = m_next(c, d[i]);
        end
        if (hand) c = hcrc;
        for (int i = 15; i >= 0; i--) begin
            e = '{d: c[i], c: 1'b1, l: (i == 0)};
            exp_q.push_back(e);
        end
        gap_q.push_back(gap);
        len_q.push_back(n + 16);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            t++;
            if (t > 200) break;
        end
        if (t > 200) begin
            chk("ready_timeout", 32'(ready_o), 32'd1);
            data_val_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!keep) data_val_i = 1'b0;
            data_i     = ~d;
            data_mod_i = m + 4'd5;
        end
    endtask

    // Monitor: every serial bit against the scoreboard, plus gaps, busy length and residue.
    logic [15:0] res;
    int          idle_run;
    int          busy_run;
    bit          prev_val;
    bit          chk_ready;

    always @(negedge clk) begin
        exp_t e;
        int   g;
        int   len;
        if (rst) begin
            res       = 16'h0000;
            idle_run  = 0;
            busy_run  = 0;
            prev_val  = 1'b0;
            chk_ready = 1'b0;
        end else begin
            if (chk_ready) begin
                chk("ready_after_frame", 32'(ready_o), 32'd1);
                chk_ready = 1'b0;
            end
            if (ser_data_val_o) begin
                if (!prev_val && gap_q.size() > 0) begin
                    g = gap_q.pop_front();
                    if (g >= 0) chk("idle_gap", 32'(idle_run), 32'(g));
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'(ser_data_val_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("serial_bit", {28'd0, ser_data_o, ser_crc_o, ser_last_o, busy_o},
                        {28'd0, e.d, e.c, e.l, 1'b1});
                end
                res = m_next(res, ser_data_o);
                if (ser_last_o) begin
                    chk("residue", 32'(res), 32'd0);
                    res       = 16'h0000;
                    chk_ready = 1'b1;
                end
                idle_run = 0;
            end else begin
                chk("idle_outputs", {28'd0, busy_o, ser_data_o, ser_crc_o, ser_last_o}, 32'd0);
                idle_run++;
            end
            if (busy_o) begin
                busy_run++;
            end else if (busy_run != 0) begin
                if (len_q.size() > 0) begin
                    len = len_q.pop_front();
                    chk("busy_len", 32'(busy_run), 32'(len));
                end
                busy_run = 0;
            end
            prev_val = ser_data_val_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        // Test 1: reset state and ready rising one edge after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, ready_o, busy_o, ser_data_val_o, ser_data_o, ser_crc_o, ser_last_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(ready_o), 32'd1);

        // Test 2-4: hand-computed frames.
        send(16'h0001, 4'd1, -1, 1'b1, 16'h8005, 1'b0);
        send(16'h0003, 4'd2, -1, 1'b1, 16'h000A, 1'b0);
        send(16'h0000, 4'd0, -1, 1'b1, 16'h0000, 1'b0);

        // Test 5: back-to-back random frames with data_val_i held high.
        for (int k = 0; k < 10; k++) begin
            send(16'($urandom), 4'($urandom_range(0, 15)), (k == 0) ? -1 : 1, 1'b0, 16'h0, (k != 9));
        end

        // Test 6: abort on payload bit 5, then a clean all-ones frame.
        send(16'hA5C3, 4'd0, -1, 1'b0, 16'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_async", {26'd0, ready_o, busy_o, ser_data_val_o, ser_data_o, ser_crc_o, ser_last_o}, 32'd0);
        exp_q.delete();
        gap_q.delete();
        len_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        send(16'hFFFF, 4'd0, -1, 1'b0, 16'h0, 1'b0);

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
